// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped tagged BTB plus a PHT of 2-bit counters.
// Define BP_GSHARE_EN for gshare indexing (PC xor global history); default build is bimodal.
module branch_predictor #(
   parameter int INDEX_BITS = 5
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [31:0]           if_pc_i,
   input  logic                  if_valid_i,
   output logic                  pred_taken_o,
   output logic [31:0]           pred_target_o,
   output logic [31:0]           next_pc_o,
   output logic [INDEX_BITS-1:0] pred_bhr_o,
   input  logic                  upd_valid_i,
   input  logic [31:0]           upd_pc_i,
   input  logic                  upd_is_branch_i,
   input  logic                  upd_is_jump_i,
   input  logic                  upd_taken_i,
   input  logic [31:0]           upd_target_i,
   input  logic [INDEX_BITS-1:0] upd_bhr_i,
   input  logic                  upd_mispredict_i
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_W   = 30 - INDEX_BITS;

   logic [ENTRIES-1:0]    btb_valid_q, btb_valid_d;
   logic [ENTRIES-1:0]    btb_cond_q;
   logic [TAG_W-1:0]      btb_tag_q [ENTRIES];
   logic [31:0]           btb_tgt_q [ENTRIES];
   logic [1:0]            pht_q [ENTRIES];
   logic [1:0]            pht_d [ENTRIES];
   logic [INDEX_BITS-1:0] bhr_q, bhr_d;

   logic [INDEX_BITS-1:0] lk_idx_s, lk_pidx_s, up_idx_s, up_pidx_s;
   logic                  lk_hit_s, lk_cond_s, pred_taken_s, btb_wr_s;
   logic [31:0]           pc_plus4_s;

   function automatic logic [INDEX_BITS-1:0] idx_of(input logic [31:0] pc);
      return pc[INDEX_BITS+1:2];
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
      return pc[31:INDEX_BITS+2];
   endfunction

   function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      case (ctr)
         2'b00:   res = taken ? 2'b01 : 2'b00;
         2'b01:   res = taken ? 2'b10 : 2'b00;
         2'b10:   res = taken ? 2'b11 : 2'b01;
         2'b11:   res = taken ? 2'b11 : 2'b10;
         default: res = ctr;
      endcase
      return res;
   endfunction

   assign lk_idx_s   = idx_of(if_pc_i);
   assign up_idx_s   = idx_of(upd_pc_i);
   assign lk_hit_s   = btb_valid_q[lk_idx_s] && (btb_tag_q[lk_idx_s] == tag_of(if_pc_i));
   assign lk_cond_s  = btb_cond_q[lk_idx_s];
   assign pc_plus4_s = if_pc_i + 32'd4;
   assign btb_wr_s   = upd_valid_i && (upd_is_branch_i || upd_is_jump_i) && upd_taken_i;

`ifdef BP_GSHARE_EN
   assign lk_pidx_s = lk_idx_s ^ bhr_q;
   assign up_pidx_s = up_idx_s ^ upd_bhr_i;
`else
   assign lk_pidx_s = lk_idx_s;
   assign up_pidx_s = up_idx_s;
`endif

   assign pred_taken_s  = lk_hit_s && (!lk_cond_s || pht_q[lk_pidx_s][1]);
   assign pred_taken_o  = pred_taken_s;
   assign pred_target_o = lk_hit_s ? btb_tgt_q[lk_idx_s] : pc_plus4_s;
   assign next_pc_o     = pred_taken_s ? btb_tgt_q[lk_idx_s] : pc_plus4_s;
   assign pred_bhr_o    = bhr_q;

   // Counter training; lookups this cycle still see the old value.
   always_comb begin
      pht_d = pht_q;
      if (upd_valid_i && upd_is_branch_i) begin
         pht_d[up_pidx_s] = sat_next(pht_q[up_pidx_s], upd_taken_i);
      end else begin
         pht_d = pht_q;
      end
   end

   // BTB allocation only on taken outcomes.
   always_comb begin
      btb_valid_d = btb_valid_q;
      if (btb_wr_s) begin
         btb_valid_d[up_idx_s] = 1'b1;
      end else begin
         btb_valid_d = btb_valid_q;
      end
   end

`ifdef BP_GSHARE_EN
   logic unused_s;
   assign unused_s = ^upd_pc_i[1:0];

   // History: misprediction repair beats the speculative shift of the flushed fetch.
   always_comb begin
      bhr_d = bhr_q;
      if (upd_valid_i && upd_mispredict_i) begin
         if (upd_is_branch_i) begin
            bhr_d = {upd_bhr_i[INDEX_BITS-2:0], upd_taken_i};
         end else begin
            bhr_d = upd_bhr_i;
         end
      end else if (if_valid_i && lk_hit_s && lk_cond_s) begin
         bhr_d = {bhr_q[INDEX_BITS-2:0], pred_taken_s};
      end else begin
         bhr_d = bhr_q;
      end
   end
`else
   logic unused_s;
   assign unused_s = ^{upd_pc_i[1:0], upd_bhr_i, if_valid_i, upd_mispredict_i};

   // Bimodal build keeps no history.
   always_comb begin
      bhr_d = '0;
   end
`endif

   // Resettable state: valid bits, counters and history.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         btb_valid_q <= '0;
         bhr_q       <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            pht_q[i] <= 2'b01;
         end
      end else begin
         btb_valid_q <= btb_valid_d;
         bhr_q       <= bhr_d;
         pht_q       <= pht_d;
      end
   end

   // Entry payload is qualified by the valid bit, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (btb_wr_s && !reset_i) begin
         btb_tag_q[up_idx_s]  <= tag_of(upd_pc_i);
         btb_tgt_q[up_idx_s]  <= upd_target_i;
         btb_cond_q[up_idx_s] <= upd_is_branch_i;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, history sequence,
// and randomized traffic against an array-based reference model.
module tb_branch_predictor;

`ifdef BP_GSHARE_EN
   localparam bit GS = 1'b1;
`else
   localparam bit GS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, if_valid, upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_mispredict;
   logic [31:0] if_pc, upd_pc, upd_target;
   logic [4:0]  upd_bhr;
   logic        pred_taken;
   logic [31:0] pred_target, next_pc;
   logic [4:0]  pred_bhr;

   int n_cmp = 0;
   int n_mis = 0;

   branch_predictor #(.INDEX_BITS(5)) dut (
      .clk_i(clk), .reset_i(reset), .if_pc_i(if_pc), .if_valid_i(if_valid),
      .pred_taken_o(pred_taken), .pred_target_o(pred_target), .next_pc_o(next_pc),
      .pred_bhr_o(pred_bhr), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
      .upd_is_branch_i(upd_is_branch), .upd_is_jump_i(upd_is_jump), .upd_taken_i(upd_taken),
      .upd_target_i(upd_target), .upd_bhr_i(upd_bhr), .upd_mispredict_i(upd_mispredict)
   );

   always #5 clk = ~clk;

   // Reference model: plain arrays indexed by (pc/4)%32, tag = pc/128, counters as 0..3.
   bit          m_valid [32];
   bit          m_cond  [32];
   int unsigned m_tag   [32];
   int unsigned m_tgt   [32];
   int          m_ctr   [32];
   int unsigned m_bhr;

   function automatic int unsigned midx(input int unsigned pc);
      return (pc / 4) % 32;
   endfunction

   function automatic int unsigned mtag(input int unsigned pc);
      return pc / 128;
   endfunction

   task automatic model_predict(output bit tk, output int unsigned tgt, output int unsigned nxt,
                                output bit hit, output bit cond);
      int unsigned i, p;
      i    = midx(if_pc);
      hit  = m_valid[i] && (m_tag[i] == mtag(if_pc));
      cond = m_cond[i];
      p    = GS ? (i ^ m_bhr) : i;
      tk   = hit && (!cond || m_ctr[p] >= 2);
      tgt  = hit ? m_tgt[i] : if_pc + 32'd4;
      nxt  = tk ? tgt : if_pc + 32'd4;
   endtask

   task automatic model_step();
      bit tk, hit, cond;
      int unsigned tgt, nxt, p, ub;
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
         end
         m_bhr = 0;
         return;
      end
      model_predict(tk, tgt, nxt, hit, cond);
      ub = int'(upd_bhr);
      if (upd_valid && upd_is_branch) begin
         p = GS ? (midx(upd_pc) ^ ub) : midx(upd_pc);
         if (upd_taken) m_ctr[p] = (m_ctr[p] < 3) ? m_ctr[p] + 1 : 3;
         else           m_ctr[p] = (m_ctr[p] > 0) ? m_ctr[p] - 1 : 0;
      end
      if (upd_valid && (upd_is_branch || upd_is_jump) && upd_taken) begin
         m_valid[midx(upd_pc)] = 1'b1;
         m_tag[midx(upd_pc)]   = mtag(upd_pc);
         m_tgt[midx(upd_pc)]   = upd_target;
         m_cond[midx(upd_pc)]  = upd_is_branch;
      end
      if (GS) begin
         if (upd_valid && upd_mispredict)
            m_bhr = upd_is_branch ? ((ub * 2) % 32 + (upd_taken ? 1 : 0)) : ub;
         else if (if_valid && hit && cond)
            m_bhr = (m_bhr * 2) % 32 + (tk ? 1 : 0);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_check(input string nm);
      bit tk, hit, cond;
      int unsigned tgt, nxt;
      model_predict(tk, tgt, nxt, hit, cond);
      chk({nm, ".taken"},  {31'd0, pred_taken}, {31'd0, tk});
      chk({nm, ".target"}, pred_target, tgt);
      chk({nm, ".next"},   next_pc, nxt);
      chk({nm, ".bhr"},    {27'd0, pred_bhr}, m_bhr);
   endtask

   task automatic drive(input bit rst, input bit ifv, input logic [31:0] pc, input bit uv,
                        input logic [31:0] upc, input bit br, input bit jp, input bit tk,
                        input logic [31:0] ut, input logic [4:0] ub, input bit mp);
      reset = rst; if_valid = ifv; if_pc = pc; upd_valid = uv; upd_pc = upc;
      upd_is_branch = br; upd_is_jump = jp; upd_taken = tk; upd_target = ut;
      upd_bhr = ub; upd_mispredict = mp;
   endtask

   task automatic end_cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          rst;
      logic [31:0] pc;
      bit          uv;
      logic [31:0] upc;
      bit          br, jp, tk;
      logic [31:0] ut;
      bit          etk;
      logic [31:0] enx;
      string       nm;
   } vec_t;

   function automatic vec_t mk(input bit rst, input logic [31:0] pc, input bit uv,
                               input logic [31:0] upc, input bit br, input bit jp, input bit tk,
                               input logic [31:0] ut, input bit etk, input logic [31:0] enx,
                               input string nm);
      vec_t v;
      v.rst = rst; v.pc = pc; v.uv = uv; v.upc = upc; v.br = br; v.jp = jp; v.tk = tk;
      v.ut = ut; v.etk = etk; v.enx = enx; v.nm = nm;
      return v;
   endfunction

   vec_t tbl [18];
   logic [31:0] tag_pool [4];

   initial begin
      tbl[0]  = mk(1'b0, 32'h40,       1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h44,  "reset_lookup");
      tbl[1]  = mk(1'b0, 32'h40,       1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h44,  "same_cycle_old");
      tbl[2]  = mk(1'b0, 32'h40,       1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, "jal_hit");
      tbl[3]  = mk(1'b0, 32'h840,      1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h844, "tag_alias");
      tbl[4]  = mk(1'b0, 32'h80,       1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h84,  "br_t1");
      tbl[5]  = mk(1'b0, 32'h80,       1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200, "br_t2");
      tbl[6]  = mk(1'b0, 32'h80,       1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200, "br_sat_hi");
      tbl[7]  = mk(1'b0, 32'h80,       1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h200, "br_nt1");
      tbl[8]  = mk(1'b0, 32'h80,       1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h200, "br_nt2");
      tbl[9]  = mk(1'b0, 32'h80,       1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h84,  "br_weak_nt");
      tbl[10] = mk(1'b0, 32'h80,       1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h84,  "br_retrain");
      tbl[11] = mk(1'b0, 32'h80,       1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, "br_weak_t");
      tbl[12] = mk(1'b0, 32'hC0,       1'b1, 32'hC0, 1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 32'hC4,  "nt_no_alloc0");
      tbl[13] = mk(1'b0, 32'hC0,       1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC4,  "nt_no_alloc1");
      tbl[14] = mk(1'b1, 32'h40,       1'b1, 32'hC0, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h100, "reset_cycle");
      tbl[15] = mk(1'b0, 32'h40,       1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h44,  "post_reset");
      tbl[16] = mk(1'b0, 32'hC0,       1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC4,  "reset_blocks_upd");
      tbl[17] = mk(1'b0, 32'hFFFFFFFC, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   "pc_wrap");
      tag_pool[0] = 32'h0; tag_pool[1] = 32'h80; tag_pool[2] = 32'h100; tag_pool[3] = 32'hFFFFFF80;

      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      end_cycle();

      // Directed table; if_valid stays low so history is zero in either build.
      for (int k = 0; k < 18; k++) begin
         drive(tbl[k].rst, 1'b0, tbl[k].pc, tbl[k].uv, tbl[k].upc, tbl[k].br, tbl[k].jp,
               tbl[k].tk, tbl[k].ut, 5'd0, 1'b0);
         #4;
         chk({tbl[k].nm, ".taken"}, {31'd0, pred_taken}, {31'd0, tbl[k].etk});
         chk({tbl[k].nm, ".next"},  next_pc, tbl[k].enx);
         chk({tbl[k].nm, ".bhr"},   {27'd0, pred_bhr}, 32'd0);
         end_cycle();
      end

      // History sequence: train a conditional branch, three predicted-taken fetches, then repair.
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      end_cycle();
      drive(1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h300, 5'd0, 1'b0);
      #4; model_check("hist_train0"); end_cycle();
      drive(1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h300, 5'd1, 1'b0);
      #4; model_check("hist_train1"); end_cycle();
      drive(1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h300, 5'd3, 1'b0);
      #4; model_check("hist_train2"); end_cycle();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
         #4;
         chk("hist_hit.taken", {31'd0, pred_taken}, 32'd1);
         chk("hist_hit.next",  next_pc, 32'h300);
         end_cycle();
      end
      drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h84, 5'b00011, 1'b1);
      #4;
      chk("hist_shifted.bhr", {27'd0, pred_bhr}, GS ? 32'd7 : 32'd0);
      end_cycle();
      drive(1'b0, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      #4;
      chk("hist_repaired.bhr", {27'd0, pred_bhr}, GS ? 32'd6 : 32'd0);
      end_cycle();

      // Randomized traffic against the reference model.
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      end_cycle();
      for (int n = 0; n < 3000; n++) begin
         int unsigned kind;
         logic [31:0] pc_r, upc_r;
         pc_r  = tag_pool[$urandom_range(0, 3)] | (32'($urandom_range(0, 31)) << 2);
         upc_r = tag_pool[$urandom_range(0, 3)] | (32'($urandom_range(0, 31)) << 2);
         kind  = $urandom_range(0, 3);
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, pc_r,
               $urandom_range(0, 1) == 1, upc_r, kind == 1 || kind == 2, kind == 3,
               $urandom_range(0, 2) != 0, $urandom, 5'($urandom_range(0, 31)),
               $urandom_range(0, 7) == 0);
         #4;
         model_check("rand");
         end_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch prediction unit for the pipelined RISC-V core: a direct-mapped tagged branch target buffer plus a pattern history table of 2-bit saturating counters indexed gshare-style by PC and global history. It sits directly upstream of the branch target/next-PC logic: each cycle it reads the IF-stage PC and supplies predicted direction, predicted target and next PC. It is trained from EX-stage resolution, which also drives misprediction history recovery.

## Interface
Parameters:
- INDEX_BITS, 5, log2 of BTB/PHT entries (32); also global history register (BHR) width.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- if_pc  in  32  PC in IF stage
- if_valid  in  1  IF advances this cycle (not stalled/flushed)
- pred_taken  out  1  predicted taken
- pred_target  out  32  BTB target on hit, else if_pc+4
- next_pc  out  32  pred_taken ? pred_target : if_pc+4
- pred_bhr  out  INDEX_BITS  BHR snapshot used for this prediction; carried down the pipe
- upd_valid  in  1  EX resolution valid this cycle
- upd_pc  in  32  PC of resolved instruction
- upd_is_branch  in  1  conditional branch
- upd_is_jump  in  1  JAL/JALR
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual target
- upd_bhr  in  INDEX_BITS  pred_bhr snapshot carried with the instruction
- upd_mispredict  in  1  direction or target mispredicted; pipeline flush

## Operation
- Index field idx(pc) = pc[INDEX_BITS+1:2]; tag(pc) = pc[31:INDEX_BITS+2].
- BTB entry: valid, tag, target[31:0], is_cond. PHT entry: 2-bit counter.
- Lookup (combinational): hit = valid[idx(if_pc)] && tag match. PHT read index p = idx(if_pc) XOR BHR. pred_taken = hit && (!is_cond || pht[p][1]).
- PHT train: upd_valid && upd_is_branch → counter at idx(upd_pc) XOR upd_bhr saturates up (taken) / down (not taken); 2'b11 and 2'b00 hold.
- BTB write: upd_valid && (upd_is_branch || upd_is_jump) && upd_taken → entry idx(upd_pc) overwritten: valid=1, tag, target=upd_target, is_cond=upd_is_branch. Not-taken outcomes never allocate or invalidate.
- BHR, priority order:
  1. upd_valid && upd_mispredict → BHR = upd_is_branch ? {upd_bhr[INDEX_BITS-2:0], upd_taken} : upd_bhr.
  2. else if_valid && hit && is_cond → BHR = {BHR[INDEX_BITS-2:0], pred_taken}.
  3. else hold.
- Mispredict recovery overrides a simultaneous speculative shift (that fetch is flushed).
- pred_bhr = current BHR (pre-update value).

## Timing
- Prediction outputs combinational from if_pc and current state; zero-cycle latency.
- All training/BHR writes take effect at the posedge of the upd_valid cycle, visible to lookups the next cycle. Same-cycle read and write of the same entry: read returns old contents (no bypass).
- reset at posedge: all BTB valid=0, all PHT counters=2'b01 (weakly not taken), BHR=0. reset overrides upd_valid and if_valid that cycle. After reset: pred_taken=0, pred_target=next_pc=if_pc+4, pred_bhr=0.
- BTB target and tag storage need not be reset.
- if_pc+4 wraps modulo 2^32 (0xFFFFFFFC → 0x00000000).
- Tag alias (same idx, different tag): miss, predict not taken; a later taken update overwrites the entry.

## Configuration
- BP_GSHARE_EN defined: PHT index = idx XOR BHR as above, BHR maintained.
- Undefined: bimodal; PHT index = idx(pc) for both lookup and train, BHR held at 0, pred_bhr=0, upd_bhr ignored. BTB behaviour unchanged.

## Test plan
- Reset then if_pc=0x40 → pred_taken=0, next_pc=0x44, pred_bhr=0.
- upd JAL pc=0x40 taken target=0x100, then if_pc=0x40 → pred_taken=1, next_pc=0x100; if_pc=0x840 (same idx, other tag) → next_pc=0x844.
- Branch pc=0x80 trained taken twice (upd_bhr=0, bimodal build) → counter 01→10→11, next_pc=target; two not-taken → 11→10→01, next_pc=0x84; extra taken beyond 11 holds 11.
- Gshare build: BHR=0, three if_valid hits on conditional entry predicted taken → BHR=0b00111; upd_mispredict with upd_bhr=0b00011, upd_taken=0, same cycle as if_valid hit → BHR=0b00110.
- Same-cycle upd write and lookup at idx 16 (pc 0x40) → lookup returns pre-write prediction; next cycle returns new.
- Assert reset mid-run after training → next cycle all lookups miss, BHR=0; if_pc=0xFFFFFFFC → next_pc=0x0.
